// File: rtl/pep9_instr_fetch_pkg.sv
// Shared definitions for the Pep9 instruction fetch unit: opcodes, FSM encoding
// and the unary-instruction decode.
package pep9_instr_fetch_pkg;

  localparam logic [7:0] OP_STOP = 8'h00;
  localparam logic [7:0] OP_BR   = 8'h12;
  localparam logic [7:0] OP_NOP0 = 8'h26;
  localparam logic [7:0] OP_NOP1 = 8'h27;

  typedef enum logic [2:0] {
    StIdle,
    StRdIs,
    StRdHi,
    StRdLo,
    StValid
  } fetch_state_e;

  // Everything below BR, plus the two NOPn traps, carries no operand specifier.
  function automatic logic pep9_is_unary(input logic [7:0] op);
    return (op < OP_BR) || (op == OP_NOP0) || (op == OP_NOP1);
  endfunction

endpackage

// File: rtl/pep9_instr_fetch_if.sv
// Memory read port and CPU instruction handshake of the fetch unit.
interface pep9_instr_fetch_if;

  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  logic        instr_valid;
  logic        instr_ready;
  logic [7:0]  InstructionSpecifier;
  logic [15:0] OperandSpecifier;
  logic [15:0] instr_pc;
  logic        is_unary;

  modport master (
    output mem_rd, mem_addr, instr_valid, InstructionSpecifier, OperandSpecifier,
           instr_pc, is_unary,
    input  mem_ack, mem_rdata, instr_ready
  );

  modport slave (
    input  mem_rd, mem_addr, instr_valid, InstructionSpecifier, OperandSpecifier,
           instr_pc, is_unary,
    output mem_ack, mem_rdata, instr_ready
  );

endinterface

// File: rtl/pep9_instr_fetch.sv
// Pep9 instruction fetch: reads IS (and big-endian OS for non-unary) byte by byte
// and presents the complete instruction through a valid/ready handshake.
module pep9_instr_fetch
  import pep9_instr_fetch_pkg::*;
#(
  parameter logic [15:0] RESET_PC     = 16'h0000,
  parameter bit          HALT_ON_STOP = 1'b1
) (
  input  logic                  Sysclk,
  input  logic                  reset,
  input  logic                  run,
  input  logic                  pc_load,
  input  logic [15:0]           pc_load_value,
  output logic                  halted,
  pep9_instr_fetch_if.master    bus
);

  fetch_state_e state_q, state_d;
  logic [15:0]  pc_q, pc_d;
  logic [15:0]  addr_q, addr_d;
  logic [7:0]   is_q, is_d;
  logic [15:0]  os_q, os_d;
  logic [15:0]  ipc_q, ipc_d;
  logic         unary_q, unary_d;
  logic         halted_q, halted_d;
  logic         flush_q, flush_d;

  logic in_rd, drop, accept;

  assign in_rd  = (state_q == StRdIs) || (state_q == StRdHi) || (state_q == StRdLo);
  // A byte returning after (or alongside) a redirect belongs to the old stream.
  assign drop   = flush_q || pc_load;
  assign accept = in_rd && bus.mem_ack && !drop;

  always_ff @(posedge Sysclk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (run && !halted_q) state_d = StRdIs;
      StRdIs: begin
        if (bus.mem_ack) begin
          if (drop)                              state_d = StIdle;
          else if (pep9_is_unary(bus.mem_rdata)) state_d = StValid;
          else                                   state_d = StRdHi;
        end
      end
      StRdHi:  if (bus.mem_ack) state_d = drop ? StIdle : StRdLo;
      StRdLo:  if (bus.mem_ack) state_d = drop ? StIdle : StValid;
      StValid: if (pc_load || bus.instr_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    pc_d     = pc_q;
    is_d     = is_q;
    os_d     = os_q;
    ipc_d    = ipc_q;
    unary_d  = unary_q;
    halted_d = halted_q;
    flush_d  = flush_q;

    if (accept) pc_d = pc_q + 16'd1;

    if (accept && state_q == StRdIs) begin
      is_d    = bus.mem_rdata;
      unary_d = pep9_is_unary(bus.mem_rdata);
      ipc_d   = pc_q;
      os_d    = 16'h0000;
    end
    if (accept && state_q == StRdHi) os_d[15:8] = bus.mem_rdata;
    if (accept && state_q == StRdLo) os_d[7:0]  = bus.mem_rdata;

    if (in_rd && bus.mem_ack)  flush_d = 1'b0;
    else if (in_rd && pc_load) flush_d = 1'b1;

    if (state_q == StValid && bus.instr_ready && HALT_ON_STOP && is_q == OP_STOP) begin
      halted_d = 1'b1;
    end

    if (pc_load) begin
      pc_d     = pc_load_value;
      halted_d = 1'b0;
    end

    // Memory reads cannot be cancelled, so the address holds until the ack.
    addr_d = (in_rd && !bus.mem_ack) ? addr_q : pc_d;
  end

  always_ff @(posedge Sysclk or posedge reset) begin
    if (reset) begin
      pc_q     <= RESET_PC;
      addr_q   <= RESET_PC;
      is_q     <= 8'h00;
      os_q     <= 16'h0000;
      ipc_q    <= RESET_PC;
      unary_q  <= 1'b0;
      halted_q <= 1'b0;
      flush_q  <= 1'b0;
    end else begin
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      is_q     <= is_d;
      os_q     <= os_d;
      ipc_q    <= ipc_d;
      unary_q  <= unary_d;
      halted_q <= halted_d;
      flush_q  <= flush_d;
    end
  end

  always_comb begin
    bus.mem_rd               = in_rd;
    bus.mem_addr             = addr_q;
    bus.instr_valid          = (state_q == StValid);
    bus.InstructionSpecifier = is_q;
    bus.OperandSpecifier     = os_q;
    bus.instr_pc             = ipc_q;
    bus.is_unary             = unary_q;
    halted                   = halted_q;
  end

endmodule

// File: tb/tb_pep9_instr_fetch.sv
// Directed bench for pep9_instr_fetch with a wait-state configurable byte memory.
module tb_pep9_instr_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        run;
  logic        pc_load;
  logic [15:0] pc_val;
  logic        ready;
  logic        halted;
  int          wait_cfg;
  int          cnt = 0;
  int          n_cmp = 0;
  int          n_err = 0;
  logic [7:0]  mem [65536];

  pep9_instr_fetch_if bus ();

  pep9_instr_fetch #(
    .RESET_PC     (16'h0000),
    .HALT_ON_STOP (1'b1)
  ) dut (
    .Sysclk        (clk),
    .reset         (rst),
    .run           (run),
    .pc_load       (pc_load),
    .pc_load_value (pc_val),
    .halted        (halted),
    .bus           (bus)
  );

  always #5 clk = ~clk;

  assign bus.instr_ready = ready;
  assign bus.mem_ack     = bus.mem_rd && (cnt == wait_cfg);
  assign bus.mem_rdata   = bus.mem_rd ? mem[bus.mem_addr] : 8'h00;

  always @(posedge clk) begin
    if (!bus.mem_rd || bus.mem_ack) cnt <= 0;
    else                            cnt <= cnt + 1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_rd"},     {15'd0, bus.mem_rd},            16'h0000);
    check({tag, "_addr"},   bus.mem_addr,                   16'h0000);
    check({tag, "_valid"},  {15'd0, bus.instr_valid},       16'h0000);
    check({tag, "_is"},     {8'd0, bus.InstructionSpecifier}, 16'h0000);
    check({tag, "_os"},     bus.OperandSpecifier,           16'h0000);
    check({tag, "_ipc"},    bus.instr_pc,                   16'h0000);
    check({tag, "_unary"},  {15'd0, bus.is_unary},          16'h0000);
    check({tag, "_halted"}, {15'd0, halted},                16'h0000);
  endtask

  task automatic check_instr(input string tag, input logic [7:0] is, input logic [15:0] os,
                             input logic [15:0] ipc, input logic unary);
    check({tag, "_valid"}, {15'd0, bus.instr_valid},          16'h0001);
    check({tag, "_is"},    {8'd0, bus.InstructionSpecifier},  {8'd0, is});
    check({tag, "_os"},    bus.OperandSpecifier,              os);
    check({tag, "_ipc"},   bus.instr_pc,                      ipc);
    check({tag, "_unary"}, {15'd0, bus.is_unary},             {15'd0, unary});
  endtask

  task automatic check_rd(input string tag, input logic rd, input logic [15:0] addr);
    check({tag, "_rd"}, {15'd0, bus.mem_rd}, {15'd0, rd});
    if (rd) check({tag, "_addr"}, bus.mem_addr, addr);
  endtask

  initial begin
    int          cyc;
    logic [15:0] pa;
    logic        pr, pk;

    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[16'h0000] = 8'h08; mem[16'h0001] = 8'h12; mem[16'h0002] = 8'h00; mem[16'h0003] = 8'h34;
    mem[16'h0010] = 8'hC0; mem[16'h0011] = 8'hAB; mem[16'h0012] = 8'hCD;
    mem[16'h0040] = 8'hC0; mem[16'h0041] = 8'h55; mem[16'h0042] = 8'h66;
    mem[16'h0100] = 8'h26;
    mem[16'h0020] = 8'h26;
    mem[16'hFFFF] = 8'hC0;

    rst = 1'b1; run = 1'b0; pc_load = 1'b0; pc_val = 16'h0000; ready = 1'b0; wait_cfg = 0;
    #12;
    check_reset("reset");

    // Zero-wait unary then non-unary
    @(posedge clk); #1;
    rst = 1'b0; run = 1'b1;
    tick(); check_rd("t1_rdis", 1'b1, 16'h0000);
    tick(); check_instr("t1_negr", 8'h08, 16'h0000, 16'h0000, 1'b1);
    tick(); check_instr("t1_hold", 8'h08, 16'h0000, 16'h0000, 1'b1);
    ready = 1'b1;
    tick(); check("t1_hs_valid", {15'd0, bus.instr_valid}, 16'h0000);
    ready = 1'b0;
    tick(); check_rd("t1_rd_is2", 1'b1, 16'h0001);
    tick(); check_rd("t1_rd_hi2", 1'b1, 16'h0002);
    tick(); check_rd("t1_rd_lo2", 1'b1, 16'h0003);
    tick(); check_instr("t1_br", 8'h12, 16'h0034, 16'h0001, 1'b0);
    run = 1'b0; ready = 1'b1;
    tick(); check("t1_hs2_valid", {15'd0, bus.instr_valid}, 16'h0000);
    ready = 1'b0;
    tick(); check("t1_park_rd", {15'd0, bus.mem_rd}, 16'h0000);

    // Two-wait memory, non-unary at 0x0010, address stable while waiting
    wait_cfg = 2; pc_val = 16'h0010; pc_load = 1'b1; run = 1'b1;
    tick(); pc_load = 1'b0;
    cyc = 0;
    while (!bus.instr_valid && cyc < 20) begin
      pr = bus.mem_rd; pa = bus.mem_addr; pk = bus.mem_ack;
      tick(); cyc++;
      if (pr && !pk && bus.mem_rd) check("t2_addr_stable", bus.mem_addr, pa);
    end
    check("t2_latency", cyc[15:0], 16'd9);
    check_instr("t2_c0", 8'hC0, 16'hABCD, 16'h0010, 1'b0);

    // pc_load with handshake, then pc_load during an outstanding RD_HI read
    ready = 1'b1; pc_load = 1'b1; pc_val = 16'h0040;
    tick(); pc_load = 1'b0; ready = 1'b0;
    check("t3_hs_valid", {15'd0, bus.instr_valid}, 16'h0000);
    check("t3_newpc", bus.mem_addr, 16'h0040);
    tick(); check_rd("t3_rdis", 1'b1, 16'h0040);
    tick(); tick(); tick();
    check_rd("t3_rdhi", 1'b1, 16'h0041);
    pc_load = 1'b1; pc_val = 16'h0100;
    tick(); pc_load = 1'b0;
    check_rd("t3_flush0", 1'b1, 16'h0041);
    check("t3_flush0_valid", {15'd0, bus.instr_valid}, 16'h0000);
    tick();
    check_rd("t3_flush1", 1'b1, 16'h0041);
    check("t3_flush1_valid", {15'd0, bus.instr_valid}, 16'h0000);
    tick();
    check_rd("t3_idle", 1'b0, 16'h0000);
    check("t3_idle_valid", {15'd0, bus.instr_valid}, 16'h0000);
    tick(); check_rd("t3_redirect", 1'b1, 16'h0100);
    tick(); tick(); tick();
    check_instr("t3_nop0", 8'h26, 16'h0000, 16'h0100, 1'b1);
    ready = 1'b1; run = 1'b0;
    tick(); ready = 1'b0; wait_cfg = 0;

    // PC wrap: IS at 0xFFFF, operand from 0x0000/0x0001
    pc_val = 16'hFFFF; pc_load = 1'b1; run = 1'b1;
    tick(); pc_load = 1'b0;
    check_rd("t4_rdis", 1'b1, 16'hFFFF);
    tick(); check_rd("t4_rdhi", 1'b1, 16'h0000);
    tick(); check_rd("t4_rdlo", 1'b1, 16'h0001);
    tick(); check_instr("t4_wrap", 8'hC0, 16'h0812, 16'hFFFF, 1'b0);
    ready = 1'b1; run = 1'b0;
    tick(); ready = 1'b0;

    // STOP halts fetch; pc_load resumes it
    mem[16'h0000] = 8'h00;
    pc_val = 16'h0000; pc_load = 1'b1; run = 1'b1;
    tick(); pc_load = 1'b0;
    check_rd("t5_rdis", 1'b1, 16'h0000);
    tick(); check_instr("t5_stop", 8'h00, 16'h0000, 16'h0000, 1'b1);
    check("t5_pre_halt", {15'd0, halted}, 16'h0000);
    ready = 1'b1;
    tick(); ready = 1'b0;
    check("t5_halted", {15'd0, halted}, 16'h0001);
    check("t5_halt_valid", {15'd0, bus.instr_valid}, 16'h0000);
    tick(); tick();
    check("t5_halt_rd", {15'd0, bus.mem_rd}, 16'h0000);
    pc_val = 16'h0020; pc_load = 1'b1;
    tick(); pc_load = 1'b0;
    check("t5_unhalt", {15'd0, halted}, 16'h0000);
    cyc = 0;
    while (!bus.mem_rd && cyc < 5) begin tick(); cyc++; end
    check_rd("t5_resume", 1'b1, 16'h0020);
    tick(); check_instr("t5_nop0", 8'h26, 16'h0000, 16'h0020, 1'b1);
    ready = 1'b1; run = 1'b0;
    tick(); ready = 1'b0;

    // Asynchronous reset in the middle of RD_LO
    wait_cfg = 2; pc_val = 16'h0010; pc_load = 1'b1; run = 1'b1;
    tick(); pc_load = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    check_rd("t6_rdlo", 1'b1, 16'h0012);
    tick();
    #2; rst = 1'b1;
    #1; check_reset("t6_async");
    wait_cfg = 0;
    @(posedge clk); #1;
    rst = 1'b0;
    tick(); check_rd("t6_restart", 1'b1, 16'h0000);
    tick(); check_instr("t6_stop", 8'h00, 16'h0000, 16'h0000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pep9_instr_fetch.md
# pep9_instr_fetch

Instruction fetch unit for the Pep9 CPU hardware simulator. Reads the instruction specifier byte, and for non-unary instructions the two operand specifier bytes, from byte-wide main memory. Presents each complete instruction to the CPU through a valid/ready handshake, on the same `InstructionSpecifier` bus the CPU top consumes. Sits between the memory port and `Top_Pep9CPU`, and replaces bench-driven instruction specifiers.

## Interface
Parameters:
- `RESET_PC`, 16'h0000, PC value loaded on reset.
- `HALT_ON_STOP`, 1, when 1, fetch stops after delivering STOP (8'h00).

Ports:
- `Sysclk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `run`  in  1  fetch enable; when 0, no new memory request is issued.
- `pc_load`  in  1  redirect the PC (branch/call/return), single-cycle pulse.
- `pc_load_value`  in  16  new PC value for `pc_load`.
- `mem_rd`  out  1  memory read request; held high until `mem_ack`.
- `mem_addr`  out  16  byte address; stable while `mem_rd` is high.
- `mem_ack`  in  1  read data valid this cycle.
- `mem_rdata`  in  8  read data, sampled when `mem_ack` is high.
- `instr_valid`  out  1  complete instruction available.
- `instr_ready`  in  1  CPU accepts the instruction.
- `InstructionSpecifier`  out  8  fetched instruction specifier.
- `OperandSpecifier`  out  16  operand specifier; 16'h0000 for unary instructions.
- `instr_pc`  out  16  address of the instruction specifier byte.
- `is_unary`  out  1  1 when the instruction has no operand specifier.
- `halted`  out  1  fetch stopped after STOP.

## Operation
- Unary decode: IS < 8'h12, or IS == 8'h26, or IS == 8'h27. Every other IS is non-unary, with a 3-byte instruction.
- Operand specifier is big-endian: high byte at PC+1, low byte at PC+2.
- PC is 16 bits and increments by 1 per accepted byte. It wraps 16'hFFFF to 16'h0000 with no flag.
- States:
  - IDLE: if `run` and not `halted`, go to RD_IS.
  - RD_IS: on `mem_ack`, latch IS. If unary, go to VALID; otherwise go to RD_HI.
  - RD_HI: on `mem_ack`, latch OS[15:8] and go to RD_LO.
  - RD_LO: on `mem_ack`, latch OS[7:0] and go to VALID.
  - VALID: `instr_valid`=1. On `instr_ready`, go to IDLE. If IS == 8'h00 and `HALT_ON_STOP`=1, set `halted` instead.
- `mem_addr` is the current PC in every RD_* state. `mem_rd` is 1 in RD_* states only.
- `run` deassert: a request already outstanding completes. The FSM then parks in IDLE or VALID.
- `pc_load`:
  - PC is set to `pc_load_value` and `halted` is cleared.
  - In VALID, the held instruction is discarded and the FSM goes to IDLE.
  - In RD_* with `mem_rd` high, the request must still finish, because memory cannot be cancelled. A flush flag is set, the returning byte is dropped on `mem_ack`, and the FSM goes to IDLE. The next fetch uses the new PC.
- `pc_load` in the same cycle as the `instr_valid`&`instr_ready` handshake: the handshake completes and the CPU owns that instruction. PC takes `pc_load_value`.
- `pc_load` in the same cycle as `mem_ack`: the byte is dropped.

## Timing
- Reset values:
  - PC = `RESET_PC`, state IDLE.
  - `mem_rd`=0, `mem_addr`=`RESET_PC`.
  - `instr_valid`=0, `InstructionSpecifier`=8'h00, `OperandSpecifier`=16'h0000, `instr_pc`=`RESET_PC`.
  - `is_unary`=0, `halted`=0, flush=0.
- Reset mid-fetch aborts immediately and the outstanding read is abandoned. The memory model must tolerate `mem_rd` dropping.
- With zero-wait memory (`mem_ack` in the first cycle `mem_rd` is high), latency from IDLE to `instr_valid` is 2 cycles for unary and 4 cycles for non-unary.
- `instr_valid`, `InstructionSpecifier`, `OperandSpecifier`, `instr_pc` and `is_unary` are registered and stable from `instr_valid` rise until the handshake.
- Back-to-back throughput: one unary instruction per 3 cycles.

## Structure
- Shared package/header `pep9_defs`:
  - opcode constants `OP_STOP`=8'h00, `OP_BR`=8'h12, `OP_NOP0`=8'h26, `OP_NOP1`=8'h27;
  - FSM state encodings;
  - function `pep9_is_unary(is)`.
- Single module. The unary decode is a package function, not a sub-module.

## Test plan
- Memory[0..3] = 08 12 00 34 (IS 08 is NEGr, unary), zero-wait, `instr_ready`=1 → first instruction: IS=08, `is_unary`=1, `instr_pc`=0000, OS=0000. Second instruction: IS=12, OS=0034, `instr_pc`=0001.
- Non-unary IS 8'hC0 at 0x0010, 2-cycle `mem_ack` delay → OS assembled big-endian, and `mem_addr` is stable while `mem_rd` is high.
- `pc_load` to 0x0100 while RD_HI has an outstanding request → the byte returned by that request is dropped. The next `mem_addr` is 0x0100, with no `instr_valid` pulse for the aborted instruction.
- PC=FFFF, IS=8'hC0 → operand bytes are read from 0000 and 0001.
- STOP at 0x0000 with `HALT_ON_STOP`=1 → `halted`=1 after the handshake and `mem_rd` stays 0. `pc_load` to 0x0020 clears `halted` and fetch resumes at 0x0020.
- Assert `reset` mid-RD_LO → all outputs return to their reset values asynchronously. Release `reset` → fetch restarts at `RESET_PC`.
